// File: rtl/chunk_serial_adder_if.sv
// Operand/result bundle for chunk_serial_adder. With ADDER_SUB_EN defined the
// bundle also carries the subtract-mode request bit.
interface chunk_serial_adder_if #(
    parameter int WIDTH = 16
);
    // Handshake: the master raises start with a/b/c_in(/sub) valid; they are
    // consumed on the first rising edge where the slave is not busy. The result
    // is valid on sum/c_out/ovf in the cycle done=1 and held until the next done.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

`ifdef ADDER_SUB_EN
    modport master (output start, a, b, c_in, sub, input busy, done, sum, c_out, ovf);
    modport slave  (input start, a, b, c_in, sub, output busy, done, sum, c_out, ovf);
`else
    modport master (output start, a, b, c_in, input busy, done, sum, c_out, ovf);
    modport slave  (input start, a, b, c_in, output busy, done, sum, c_out, ovf);
`endif
endinterface

// File: rtl/chunk_serial_adder.sv
// Serial adder: WIDTH-bit a + b + c_in using one CHUNK-bit slice per clock.
// Define ADDER_SUB_EN to add the sub input (adds ~b instead of b).
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    chunk_serial_adder_if.slave  bus,
    output logic [1:0]           o_state
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_ovf;

    int               w_base;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_slice;
    logic [WIDTH-1:0] w_work_final;
    logic             w_last;
    logic             w_msb_cin;
    logic             w_accept;

    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // The single CHUNK-bit adder slice and the working value it updates.
    always_comb begin
        w_base       = int'(r_idx) * CHUNK;
        w_a_chunk    = r_a[w_base +: CHUNK];
        w_b_chunk    = r_b[w_base +: CHUNK];
        w_slice      = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_work_final = r_work;
        w_work_final[w_base +: CHUNK] = w_slice[CHUNK-1:0];
        w_last       = (r_idx == IDX_W'(NCHUNK - 1));
        // Carry into the MSB recovered from the MSB's own sum bit.
        w_msb_cin    = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_slice[CHUNK-1];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_a     <= bus.a;
`ifdef ADDER_SUB_EN
            r_b     <= bus.sub ? ~bus.b : bus.b;
`else
            r_b     <= bus.b;
`endif
            r_work  <= '0;
            r_carry <= bus.c_in;
        end else if (r_state == S_RUN) begin
            r_work  <= w_work_final;
            r_carry <= w_slice[CHUNK];
            r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
            // Visible outputs change only here, so partial sums never leak out.
            if (w_last) begin
                r_sum   <= w_work_final;
                r_c_out <= w_slice[CHUNK];
                r_ovf   <= w_msb_cin ^ w_slice[CHUNK];
            end
        end
    end

    assign bus.busy  = (r_state == S_RUN);
    assign bus.done  = (r_state == S_DONE);
    assign bus.sum   = r_sum;
    assign bus.c_out = r_c_out;
    assign bus.ovf   = r_ovf;
    assign o_state   = r_state;
endmodule

// File: tb/tb_chunk_serial_adder.sv
// Bench for chunk_serial_adder: arithmetic/timeline model checked every cycle,
// plus directed vectors with literal expected results.
module tb_chunk_serial_adder;
    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chunk_serial_adder_if #(.WIDTH(W)) bus ();
    chunk_serial_adder_if #(.WIDTH(4)) bus4 ();
    logic [1:0] st;
    logic [1:0] st4;

    chunk_serial_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst), .bus(bus), .o_state(st));
    chunk_serial_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .o_state(st4));

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {c_out, ovf, sum} for a + (sub ? ~b : b) + cin.
    function automatic logic [W+1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sb);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ov;
        bb   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W], ov, full[W-1:0]};
    endfunction

    // Model: an accepted op takes N edges, then shows its result for one cycle.
    logic [W+1:0] exp_q[$];
    int           m_left;
    logic         m_done;
    logic [W-1:0] m_sum;
    logic         m_c;
    logic         m_o;
    logic         m_sub_in;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_c    = 1'b0;
            m_o    = 1'b0;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                {m_c, m_o, m_sum} = exp_q.pop_front();
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
`ifdef ADDER_SUB_EN
            m_sub_in = bus.sub;
`else
            m_sub_in = 1'b0;
`endif
            if (bus.start) begin
                exp_q.push_back(calc(bus.a, bus.b, bus.c_in, m_sub_in));
                m_left = N;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_busy", 32'(bus.busy), 32'(m_left > 0));
            check("model_done", 32'(bus.done), 32'(m_done));
            check("model_sum", 32'(bus.sum), 32'(m_sum));
            check("model_c_out", 32'(bus.c_out), 32'(m_c));
            check("model_ovf", 32'(bus.ovf), 32'(m_o));
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sb, output logic [W-1:0] s, output logic co,
                          output logic ov, output int busy_cnt);
        bit found;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.c_in  = cin;
`ifdef ADDER_SUB_EN
        bus.sub   = sb;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt  = 0;
        found     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                found = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        check("done_timeout", 32'(found), 32'd1);
        s  = bus.sum;
        co = bus.c_out;
        ov = bus.ovf;
    endtask

    task automatic expect_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic sb, input logic [W-1:0] es,
                             input logic ec, input logic eo);
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           bc;
        run_op(a, b, cin, sb, s, co, ov, bc);
        check({name, "_sum"}, 32'(s), 32'(es));
        check({name, "_c_out"}, 32'(co), 32'(ec));
        check({name, "_ovf"}, 32'(ov), 32'(eo));
        check({name, "_busy_cycles"}, 32'(bc), 32'(N));
    endtask

    initial begin
        int done_k[$];
        logic [W-1:0] done_s[$];
        int dcnt;
        bit found;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.c_in   = 1'b0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        bus4.c_in  = 1'b0;
`ifdef ADDER_SUB_EN
        bus.sub    = 1'b0;
        bus4.sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_c_out", 32'(bus.c_out), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        expect_op("t1_small", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        expect_op("t2_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        expect_op("t3_posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        expect_op("t3_negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        expect_op("cin_mix", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        expect_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);

        // Back-to-back with start held and operands changed mid-RUN.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h0001;
        bus.b     = 16'h0002;
        bus.c_in  = 1'b0;
        @(negedge clk);
        bus.a = 16'h1111;
        bus.b = 16'h2222;
        for (int k = 0; k <= 16; k++) begin
            if (bus.done) begin
                done_k.push_back(k);
                done_s.push_back(bus.sum);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("b2b_done_count", 32'(done_k.size()), 32'd3);
        if (done_k.size() == 3) begin
            check("b2b_done_k0", 32'(done_k[0]), 32'd4);
            check("b2b_done_k1", 32'(done_k[1]), 32'd9);
            check("b2b_done_k2", 32'(done_k[2]), 32'd14);
            check("b2b_sum0", 32'(done_s[0]), 32'h0003);
            check("b2b_sum1", 32'(done_s[1]), 32'h3333);
            check("b2b_sum2", 32'(done_s[2]), 32'h3333);
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("b2b_drain", 32'(found), 32'd1);

        // Reset during the second RUN cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h00FF;
        bus.b     = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_c_out", 32'(bus.c_out), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("midrst_no_done", 32'(dcnt), 32'd0);

`ifdef ADDER_SUB_EN
        expect_op("sub_5m7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        expect_op("sub_9m3", 16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0);
`endif

        // Single-chunk instance: one RUN cycle.
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a     = 4'b1010;
        bus4.b     = 4'b0101;
        bus4.c_in  = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        check("w4_busy", 32'(bus4.busy), 32'd1);
        check("w4_done_early", 32'(bus4.done), 32'd0);
        @(negedge clk);
        check("w4_done", 32'(bus4.done), 32'd1);
        check("w4_sum", 32'(bus4.sum), 32'd0);
        check("w4_c_out", 32'(bus4.c_out), 32'd1);
        check("w4_ovf", 32'(bus4.ovf), 32'd0);
        @(negedge clk);
        check("w4_done_pulse", 32'(bus4.done), 32'd0);
        check("w4_sum_hold", 32'(bus4.sum), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
